// File: rtl/staff_frame_display_reader.sv
// Frame buffer sitting between the note-drawing write stream and the video scan path.
// Handles frame clearing, write bounds checking and keeps the display timing aligned with the pixels.
module staff_frame_display_reader #(
  parameter int          FB_WIDTH    = 320,
  parameter int          FB_HEIGHT   = 180,
  parameter int          SCALE_LOG2  = 2,
  parameter logic [7:0]  CLEAR_INDEX = 8'hFF,
  parameter logic [7:0]  STAFF_INDEX = 8'h94,
  parameter logic [23:0] STAFF_COLOR = 24'h3050A0,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_valid_in,
  input  logic [15:0] wr_addr_in,
  input  logic [15:0] wr_data_in,
  input  logic        clear_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_draw_in,
  output logic [23:0] pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic        clearing_out,
  output logic [15:0] drop_count_out,
  output logic        addr_err_out
);

  localparam int          FB_SIZE   = FB_WIDTH * FB_HEIGHT;
  localparam logic [15:0] FB_SIZE_W = 16'(FB_SIZE);
  localparam logic [15:0] LAST_ADDR = 16'(FB_SIZE - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] clear_cnt_reg, clear_cnt_next;

  always_comb begin
    state_next     = state_reg;
    clear_cnt_next = clear_cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (clear_cnt_reg == LAST_ADDR) begin
          state_next     = ST_IDLE;
          clear_cnt_next = 16'd0;
        end else begin
          clear_cnt_next = clear_cnt_reg + 16'd1;
        end
      end
      default: begin
        if (clear_in) begin
          state_next     = ST_CLEAR;
          clear_cnt_next = 16'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= ST_CLEAR;
      clear_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      clear_cnt_reg <= clear_cnt_next;
    end
  end

  // Port A: the clear sweep owns the port; stream writes only land while idle.
  logic        wr_in_range;
  logic        a_we;
  logic [15:0] a_addr;
  logic [7:0]  a_data;
  logic        unused_wr_data_hi;

  assign wr_in_range       = (wr_addr_in < FB_SIZE_W);
  assign unused_wr_data_hi = ^wr_data_in[15:8];

  always_comb begin
    a_we   = 1'b0;
    a_addr = wr_addr_in;
    a_data = wr_data_in[7:0];
    if (state_reg == ST_CLEAR) begin
      a_we   = 1'b1;
      a_addr = clear_cnt_reg;
      a_data = CLEAR_INDEX;
    end else if (wr_valid_in && wr_in_range) begin
      a_we = 1'b1;
    end
  end

  logic [15:0] drop_count_reg;
  logic        addr_err_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      drop_count_reg <= 16'd0;
      addr_err_reg   <= 1'b0;
    end else begin
      if (state_reg == ST_CLEAR && wr_valid_in && drop_count_reg != 16'hFFFF)
        drop_count_reg <= drop_count_reg + 16'd1;
      if (state_reg == ST_IDLE && wr_valid_in && !wr_in_range)
        addr_err_reg <= 1'b1;
    end
  end

  // Stage 1: downscale display coordinates into a buffer address.
  logic [10:0] x_full;
  logic [9:0]  y_full;
  logic        in_frame_comb;
  logic [15:0] addr_comb;
  logic [15:0] rd_addr_reg;

  assign x_full        = hcount_in >> SCALE_LOG2;
  assign y_full        = vcount_in >> SCALE_LOG2;
  assign in_frame_comb = active_draw_in && (x_full < 11'(FB_WIDTH)) && (y_full < 10'(FB_HEIGHT));
  assign addr_comb     = in_frame_comb ? (16'(y_full) * 16'(FB_WIDTH) + 16'(x_full)) : 16'd0;

  always_ff @(posedge clk_in) begin
    if (rst_in) rd_addr_reg <= 16'd0;
    else        rd_addr_reg <= addr_comb;
  end

  // Stages 2-3: block RAM with output register; read-first because the write and read
  // ports are separate processes sampling the array on the same edge.
  logic [7:0] fb_mem [0:FB_SIZE-1];
  logic [7:0] b_rd_reg;
  logic [7:0] b_q_reg;

  always_ff @(posedge clk_in) begin
    if (a_we) fb_mem[a_addr] <= a_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      b_rd_reg <= 8'd0;
      b_q_reg  <= 8'd0;
    end else begin
      b_rd_reg <= fb_mem[rd_addr_reg];
      b_q_reg  <= b_rd_reg;
    end
  end

  // in_frame travels stages 1-3; syncs travel all four stages.
  logic       in_frame_pipe_reg [0:2];
  logic [2:0] sync_pipe_reg     [0:3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_in_frame
    if (gi == 0) begin : g_head
      always_ff @(posedge clk_in) begin
        if (rst_in) in_frame_pipe_reg[gi] <= 1'b0;
        else        in_frame_pipe_reg[gi] <= in_frame_comb;
      end
    end else begin : g_tail
      always_ff @(posedge clk_in) begin
        if (rst_in) in_frame_pipe_reg[gi] <= 1'b0;
        else        in_frame_pipe_reg[gi] <= in_frame_pipe_reg[gi-1];
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    if (gi == 0) begin : g_head
      always_ff @(posedge clk_in) begin
        if (rst_in) sync_pipe_reg[gi] <= 3'd0;
        else        sync_pipe_reg[gi] <= {hsync_in, vsync_in, active_draw_in};
      end
    end else begin : g_tail
      always_ff @(posedge clk_in) begin
        if (rst_in) sync_pipe_reg[gi] <= 3'd0;
        else        sync_pipe_reg[gi] <= sync_pipe_reg[gi-1];
      end
    end
  end

  // Stage 4: palette index to RGB.
  logic [23:0] pixel_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in)                      pixel_reg <= BG_COLOR;
    else if (!in_frame_pipe_reg[2])  pixel_reg <= BG_COLOR;
    else if (b_q_reg == STAFF_INDEX) pixel_reg <= STAFF_COLOR;
    else                             pixel_reg <= {b_q_reg, b_q_reg, b_q_reg};
  end

  assign pixel_out       = pixel_reg;
  assign hsync_out       = sync_pipe_reg[3][2];
  assign vsync_out       = sync_pipe_reg[3][1];
  assign active_draw_out = sync_pipe_reg[3][0];
  assign clearing_out    = (state_reg == ST_CLEAR);
  assign drop_count_out  = drop_count_reg;
  assign addr_err_out    = addr_err_reg;

endmodule

// File: tb/tb_staff_frame_display_reader.sv
// Directed bench for staff_frame_display_reader: clear sweep, staff pixel, bounds, sync alignment
// and read-first behaviour, all against hand-computed values.
module tb_staff_frame_display_reader;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        wr_valid_in;
  logic [15:0] wr_addr_in;
  logic [15:0] wr_data_in;
  logic        clear_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        active_draw_in;
  logic [23:0] pixel_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        active_draw_out;
  logic        clearing_out;
  logic [15:0] drop_count_out;
  logic        addr_err_out;

  int checks   = 0;
  int failures = 0;

  staff_frame_display_reader dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .clear_in(clear_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_draw_in(active_draw_in),
    .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .active_draw_out(active_draw_out), .clearing_out(clearing_out),
    .drop_count_out(drop_count_out), .addr_err_out(addr_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    wr_valid_in = 1'b1;
    wr_addr_in  = addr;
    wr_data_in  = data;
    @(negedge clk_in);
    wr_valid_in = 1'b0;
    $display("write addr=%0d data=%h", addr, data);
  endtask

  task automatic scan(input logic [10:0] h, input logic [9:0] v, input logic act,
                      output logic [23:0] px);
    hcount_in      = h;
    vcount_in      = v;
    active_draw_in = act;
    repeat (4) @(negedge clk_in);
    px             = pixel_out;
    active_draw_in = 1'b0;
    $display("scan h=%0d v=%0d active=%0b pixel=%h", h, v, act, px);
  endtask

  logic [23:0] px;
  logic [23:0] exp_px;
  logic [10:0] hin;
  int          clear_cycles;
  int          vrows [3];

  initial begin
    rst_in = 1'b1; wr_valid_in = 1'b0; wr_addr_in = '0; wr_data_in = '0; clear_in = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0; active_draw_in = 1'b0;
    @(negedge clk_in);
    check("rst_pixel", 32'(pixel_out), 32'h000000);
    check("rst_hsync", 32'(hsync_out), 32'd0);
    check("rst_active", 32'(active_draw_out), 32'd0);
    check("rst_drop", 32'(drop_count_out), 32'd0);
    check("rst_addr_err", 32'(addr_err_out), 32'd0);
    check("rst_clearing", 32'(clearing_out), 32'd1);
    rst_in = 1'b0;

    // Clear sweep: drop 10 writes onto already-cleared addresses 0..9, pulse clear_in twice.
    clear_cycles = 0;
    for (int i = 0; i < 70000; i++) begin
      if (!clearing_out) break;
      clear_cycles++;
      wr_valid_in = (i >= 100 && i < 110);
      wr_addr_in  = 16'(i - 100);
      wr_data_in  = 16'h0000;
      clear_in    = (i == 200 || i == 57000);
      @(negedge clk_in);
    end
    wr_valid_in = 1'b0;
    clear_in    = 1'b0;
    $display("clear sweep cycles=%0d", clear_cycles);
    check("clear_duration", 32'(clear_cycles), 32'd57600);
    check("drop_count", 32'(drop_count_out), 32'd10);
    scan(11'd0, 10'd0, 1'b1, px);     check("dropped_addr0", 32'(px), 32'hFFFFFF);
    scan(11'd12, 10'd0, 1'b1, px);    check("dropped_addr3", 32'(px), 32'hFFFFFF);
    scan(11'd36, 10'd0, 1'b1, px);    check("dropped_addr9", 32'(px), 32'hFFFFFF);
    scan(11'd640, 10'd360, 1'b1, px); check("cleared_mid", 32'(px), 32'hFFFFFF);

    // Staff pixel at (10,75); stream h=36..47 per row and compare exactly 4 cycles later.
    wr(16'd24010, 16'h0094);
    vrows[0] = 300; vrows[1] = 303; vrows[2] = 304;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 16; j++) begin
        if (j >= 4) begin
          hin    = 11'(36 + j - 4);
          exp_px = (vrows[r] < 304 && (hin >> 2) == 11'd10) ? 24'h3050A0 : 24'hFFFFFF;
          check($sformatf("stream_v%0d_h%0d", vrows[r], hin), 32'(pixel_out), 32'(exp_px));
        end
        hcount_in      = 11'(36 + j);
        vcount_in      = 10'(vrows[r]);
        active_draw_in = 1'b1;
        @(negedge clk_in);
      end
      $display("stream row v=%0d done", vrows[r]);
    end
    active_draw_in = 1'b0;
    repeat (5) @(negedge clk_in);

    // Sync alignment: hsync pulse with the staff pixel, vsync pulse one cycle later.
    hsync_in = 1'b1; hcount_in = 11'd40; vcount_in = 10'd300; active_draw_in = 1'b1;
    @(negedge clk_in);
    check("hsync_lat1", 32'(hsync_out), 32'd0);
    hsync_in = 1'b0; vsync_in = 1'b1; active_draw_in = 1'b0;
    @(negedge clk_in);
    check("hsync_lat2", 32'(hsync_out), 32'd0);
    vsync_in = 1'b0;
    @(negedge clk_in);
    check("hsync_lat3", 32'(hsync_out), 32'd0);
    @(negedge clk_in);
    check("hsync_lat4", 32'(hsync_out), 32'd1);
    check("vsync_lat4", 32'(vsync_out), 32'd0);
    check("active_lat4", 32'(active_draw_out), 32'd1);
    check("pixel_lat4", 32'(pixel_out), 32'h3050A0);
    @(negedge clk_in);
    check("hsync_lat5", 32'(hsync_out), 32'd0);
    check("vsync_lat5", 32'(vsync_out), 32'd1);
    check("active_lat5", 32'(active_draw_out), 32'd0);
    check("pixel_lat5", 32'(pixel_out), 32'h000000);
    $display("sync alignment step done");

    // Outside the stored frame or blanked.
    scan(11'd1280, 10'd300, 1'b1, px); check("oof_h1280", 32'(px), 32'h000000);
    scan(11'd40, 10'd300, 1'b0, px);   check("oof_inactive", 32'(px), 32'h000000);
    scan(11'd40, 10'd720, 1'b1, px);   check("oof_v720", 32'(px), 32'h000000);

    // Address bounds: last legal address, then first illegal one.
    wr(16'd57599, 16'h0040);
    check("addr_err_last_ok", 32'(addr_err_out), 32'd0);
    scan(11'd1276, 10'd716, 1'b1, px); check("last_pixel", 32'(px), 32'h404040);
    wr(16'd57600, 16'h0000);
    check("addr_err_set", 32'(addr_err_out), 32'd1);
    scan(11'd0, 10'd0, 1'b1, px);      check("addr0_unchanged", 32'(px), 32'hFFFFFF);
    wr(16'd100, 16'hAB11);
    check("addr_err_sticky", 32'(addr_err_out), 32'd1);
    scan(11'd400, 10'd0, 1'b1, px);    check("low_byte_only", 32'(px), 32'h111111);

    // Read-first: write lands on the same edge the RAM reads (20,50).
    hcount_in = 11'd80; vcount_in = 10'd200; active_draw_in = 1'b1;
    @(negedge clk_in);
    active_draw_in = 1'b0;
    wr_valid_in = 1'b1; wr_addr_in = 16'd16020; wr_data_in = 16'h0020;
    @(negedge clk_in);
    wr_valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("read_first_old", 32'(pixel_out), 32'hFFFFFF);
    $display("same-cycle write/read addr=16020 pixel=%h", pixel_out);
    scan(11'd80, 10'd200, 1'b1, px);   check("read_first_new", 32'(px), 32'h202020);

    check("final_clearing", 32'(clearing_out), 32'd0);
    check("final_drop", 32'(drop_count_out), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
